// File: rtl/maxpool_relu_stream.sv
// Streaming ReLU + 1-D max-pool stage.
// Consumes a signed sample stream with a valid/ready handshake. It groups each
// vector of VECLEN samples into windows of POOL consecutive samples. For each
// window it emits max(0, max(window)) through a one-entry output register.
// A window also closes at the end of a vector, so a short trailing window is
// produced when VECLEN is not a multiple of POOL.
module maxpool_relu_stream #(
  parameter int WIDTH  = 16,
  parameter int VECLEN = 32,
  parameter int POOL   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    m_last_z
);

  localparam int WP_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int VI_W = (VECLEN > 1) ? $clog2(VECLEN) : 1;
  localparam logic [WP_W-1:0] WP_LAST = WP_W'(POOL - 1);
  localparam logic [VI_W-1:0] VI_LAST = VI_W'(VECLEN - 1);

  logic [WP_W-1:0]         win_pos;
  logic [VI_W-1:0]         vec_idx;
  logic signed [WIDTH-1:0] acc;

  logic signed [WIDTH-1:0] acc_eff;
  logic signed [WIDTH-1:0] pool_max;
  logic                    vec_end;
  logic                    final_beat;
  logic                    accept;
  logic                    drain;

  // Window/vector bookkeeping and handshake.
  // s_ready_y depends combinationally on m_ready_z. This lets a final beat
  // load a new result on the same edge that the old result drains.
  always_comb begin
    vec_end    = (vec_idx == VI_LAST);
    final_beat = (win_pos == WP_LAST) || vec_end;
    s_ready_y  = !final_beat || !m_valid_z || m_ready_z;
    accept     = s_valid_y && s_ready_y;
    drain      = m_valid_z && m_ready_z;
  end

  // Running maximum. It is seeded with 0 at window start, which applies the ReLU.
  always_comb begin
    if (win_pos == '0) begin
      acc_eff = '0;
    end else begin
      acc_eff = acc;
    end
    if (s_data_in_y > acc_eff) begin
      pool_max = s_data_in_y;
    end else begin
      pool_max = acc_eff;
    end
  end

  // Window position, vector position and accumulator advance on every accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_pos <= '0;
      vec_idx <= '0;
      acc     <= '0;
    end else if (accept) begin
      if (final_beat) begin
        win_pos <= '0;
        vec_idx <= vec_end ? '0 : vec_idx + 1'b1;
      end else begin
        acc     <= pool_max;
        win_pos <= win_pos + 1'b1;
        vec_idx <= vec_idx + 1'b1;
      end
    end
  end

  // One-entry output register.
  // A final beat overwrites the register even while it drains, so no bubble
  // appears. The data field holds its value after a drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_out_z <= '0;
      m_valid_z    <= 1'b0;
      m_last_z     <= 1'b0;
    end else if (accept && final_beat) begin
      m_data_out_z <= pool_max;
      m_valid_z    <= 1'b1;
      m_last_z     <= vec_end;
    end else if (drain) begin
      m_valid_z    <= 1'b0;
      m_last_z     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Directed and soak bench for maxpool_relu_stream.
// Three instances are used: VECLEN=4, VECLEN=5 and VECLEN=32, all with POOL=2.
module tb_maxpool_relu_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic signed [15:0] a_data, a_zdata;
  logic               a_valid, a_ready, a_zvalid, a_zready, a_zlast;
  logic signed [15:0] b_data, b_zdata;
  logic               b_valid, b_ready, b_zvalid, b_zready, b_zlast;
  logic signed [15:0] c_data, c_zdata;
  logic               c_valid, c_ready, c_zvalid, c_zready, c_zlast;

  maxpool_relu_stream #(.WIDTH(16), .VECLEN(4), .POOL(2)) u_a (
    .clk(clk), .reset(reset),
    .s_data_in_y(a_data), .s_valid_y(a_valid), .s_ready_y(a_ready),
    .m_data_out_z(a_zdata), .m_valid_z(a_zvalid), .m_ready_z(a_zready), .m_last_z(a_zlast)
  );

  maxpool_relu_stream #(.WIDTH(16), .VECLEN(5), .POOL(2)) u_b (
    .clk(clk), .reset(reset),
    .s_data_in_y(b_data), .s_valid_y(b_valid), .s_ready_y(b_ready),
    .m_data_out_z(b_zdata), .m_valid_z(b_zvalid), .m_ready_z(b_zready), .m_last_z(b_zlast)
  );

  maxpool_relu_stream #(.WIDTH(16), .VECLEN(32), .POOL(2)) u_c (
    .clk(clk), .reset(reset),
    .s_data_in_y(c_data), .s_valid_y(c_valid), .s_ready_y(c_ready),
    .m_data_out_z(c_zdata), .m_valid_z(c_zvalid), .m_ready_z(c_zready), .m_last_z(c_zlast)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Partial-window vectors (VECLEN=5) with hand-computed results per beat.
  int b_in  [10] = '{1, 2, 3, 4, -9, 8, 7, 6, 5, 4};
  int b_fin [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
  int b_exp [10] = '{0, 2, 0, 4, 0, 0, 8, 0, 6, 4};
  int b_lst [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  // Soak reference model state.
  logic [15:0] qd[$];
  logic        ql[$];

  initial begin
    int wp, vi, macc, m, d, accepted, cyc;
    logic fin, exp_rdy;

    reset = 1'b0;
    a_valid = 0; a_data = '0; a_zready = 1;
    b_valid = 0; b_data = '0; b_zready = 1;
    c_valid = 0; c_data = '0; c_zready = 1;

    // ---------------- reset state ----------------
    #12;
    chk1 ("rst_valid", a_zvalid, 1'b0);
    chk1 ("rst_last",  a_zlast,  1'b0);
    chk16("rst_data",  a_zdata,  16'h0000);
    chk1 ("rst_ready", a_ready,  1'b1);
    chk1 ("rst_c_ready", c_ready, 1'b1);
    @(negedge clk); reset = 1'b1;

    // ---------------- basic pool: 5,-3,-7,-2 -> 5, 0(last) ----------------
    @(negedge clk); a_valid = 1; a_data = 16'sd5;
    @(negedge clk); chk1("basic_v_idle", a_zvalid, 1'b0); a_data = -16'sd3;
    @(negedge clk); chk1("basic_v0", a_zvalid, 1'b1); chk16("basic_d0", a_zdata, 16'd5);
                    chk1("basic_l0", a_zlast, 1'b0); a_data = -16'sd7;
    @(negedge clk); chk1("basic_v_drain", a_zvalid, 1'b0); a_data = -16'sd2;
    @(negedge clk); chk1("basic_v1", a_zvalid, 1'b1); chk16("basic_d1", a_zdata, 16'd0);
                    chk1("basic_l1", a_zlast, 1'b1); a_valid = 0;
    @(negedge clk); chk1("basic_v_end", a_zvalid, 1'b0);

    // ---------------- partial window with vector wrap (VECLEN=5) ----------------
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (b_fin[i-1] != 0) begin
          chk1 ($sformatf("part_v%0d", i-1), b_zvalid, 1'b1);
          chk16($sformatf("part_d%0d", i-1), b_zdata, 16'(b_exp[i-1]));
          chk1 ($sformatf("part_l%0d", i-1), b_zlast, b_lst[i-1] != 0);
        end else begin
          chk1 ($sformatf("part_v%0d", i-1), b_zvalid, 1'b0);
        end
      end
      if (i < 10) begin
        b_valid = 1; b_data = 16'(b_in[i]);
        #1 chk1($sformatf("part_rdy%0d", i), b_ready, 1'b1);
      end else begin
        b_valid = 0;
      end
    end

    // ---------------- backpressure ----------------
    @(negedge clk); a_valid = 1; a_data = 16'sd5;
    @(negedge clk); a_data = -16'sd3;
    @(negedge clk); chk1("bp_v0", a_zvalid, 1'b1); chk16("bp_d0", a_zdata, 16'd5);
                    a_zready = 0; a_data = -16'sd7;
                    #1 chk1("bp_rdy_nonfinal", a_ready, 1'b1);
    @(negedge clk); chk1("bp_v_hold", a_zvalid, 1'b1); chk16("bp_d_hold", a_zdata, 16'd5);
                    a_data = 16'sd9;
                    #1 chk1("bp_rdy_final_stall", a_ready, 1'b0);
    @(negedge clk); chk16("bp_d_stall", a_zdata, 16'd5); chk1("bp_v_stall", a_zvalid, 1'b1);
                    chk1("bp_rdy_still", a_ready, 1'b0);
                    a_zready = 1;
                    #1 chk1("bp_rdy_release", a_ready, 1'b1);
    @(negedge clk); chk1("bp_v_nobubble", a_zvalid, 1'b1); chk16("bp_d_new", a_zdata, 16'd9);
                    chk1("bp_l_new", a_zlast, 1'b1); a_valid = 0;
    @(negedge clk); chk1("bp_v_end", a_zvalid, 1'b0);

    // ---------------- extremes ----------------
    @(negedge clk); a_valid = 1; a_data = 16'sh7FFF;
    @(negedge clk); a_data = 16'sh8000;
    @(negedge clk); chk1("ext_v0", a_zvalid, 1'b1); chk16("ext_d0", a_zdata, 16'h7FFF);
                    a_data = 16'sh8000;
    @(negedge clk); a_data = 16'shFFFF;
    @(negedge clk); chk1("ext_v1", a_zvalid, 1'b1); chk16("ext_d1", a_zdata, 16'h0000);
                    chk1("ext_l1", a_zlast, 1'b1); a_valid = 0;
    @(negedge clk);

    // ---------------- reset mid-window ----------------
    @(negedge clk); a_valid = 1; a_data = 16'sd1;
    @(negedge clk); a_data = 16'sd2;
    @(negedge clk); chk16("rmw_d_pre", a_zdata, 16'd2); a_zready = 0; a_data = 16'sd9;
    @(negedge clk); chk1("rmw_v_held", a_zvalid, 1'b1); a_valid = 0;
                    #2 reset = 1'b0;
                    #1 chk1("rmw_v_clr", a_zvalid, 1'b0); chk16("rmw_d_clr", a_zdata, 16'h0000);
                    chk1("rmw_l_clr", a_zlast, 1'b0); chk1("rmw_rdy", a_ready, 1'b1);
    @(negedge clk); reset = 1'b1; a_zready = 1;
    @(negedge clk); a_valid = 1; a_data = 16'sd1;
    @(negedge clk); chk1("rmw_v_a", a_zvalid, 1'b0); a_data = 16'sd2;
    @(negedge clk); chk1("rmw_v0", a_zvalid, 1'b1); chk16("rmw_d0", a_zdata, 16'd2);
                    chk1("rmw_l0", a_zlast, 1'b0); a_data = 16'sd3;
    @(negedge clk); a_data = 16'sd4;
    @(negedge clk); chk1("rmw_v1", a_zvalid, 1'b1); chk16("rmw_d1", a_zdata, 16'd4);
                    chk1("rmw_l1", a_zlast, 1'b1); a_valid = 0;

    // ---------------- random soak (VECLEN=32, POOL=2) ----------------
    wp = 0; vi = 0; macc = 0; accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      c_valid  = ($urandom_range(0, 99) < 75);
      c_data   = 16'($urandom);
      c_zready = ($urandom_range(0, 99) < 70);
      #1;
      fin     = (wp == 1) || (vi == 31);
      exp_rdy = !fin || (qd.size() == 0) || c_zready;
      chk1("soak_valid", c_zvalid, qd.size() != 0);
      chk1("soak_ready", c_ready, exp_rdy);
      if (qd.size() != 0 && c_zready) begin
        chk16("soak_data", c_zdata, qd[0]);
        chk1 ("soak_last", c_zlast, ql[0]);
        void'(qd.pop_front());
        void'(ql.pop_front());
      end
      if (c_valid && exp_rdy) begin
        d = c_data;
        m = (wp == 0) ? 0 : macc;
        if (d > m) m = d;
        if (fin) begin
          qd.push_back(16'(m));
          ql.push_back(vi == 31);
          wp = 0;
          vi = (vi == 31) ? 0 : vi + 1;
        end else begin
          macc = m;
          wp++;
          vi++;
        end
        accepted++;
      end
    end
    total++;
    assert (accepted == 10000) passed++;
    else $error("FAIL soak_timeout: observed %0d accepted expected %0d", accepted, 10000);

    @(negedge clk); c_valid = 0; c_zready = 1;
    #1;
    if (qd.size() != 0) begin
      chk16("soak_tail_data", c_zdata, qd[0]);
      chk1 ("soak_tail_last", c_zlast, ql[0]);
      void'(qd.pop_front());
      void'(ql.pop_front());
    end
    @(negedge clk); #1;
    chk1("soak_final_valid", c_zvalid, 1'b0);
    chk1("soak_queue_empty", qd.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
